// File: rtl/sdram_pkg.sv
// sdram_pkg: command, error and mode-register definitions shared by the SDRAM
// emulator and the board's SDRAM controller.
//   CMD_*      4-bit {cs,ras,cas,we} command codes (cs=1 matches none of them)
//   ERR_*      protocol-violation codes reported on err_code
//   MODE_*     mode-register field positions and legal values
//   rd_tag_t   control tag that travels with a read through the latency pipe
package sdram_pkg;

    localparam int unsigned NUM_BANKS = 4;
    localparam int unsigned BA_W      = 2;
    localparam int unsigned ADDR_W    = 13;
    localparam int unsigned DQ_W      = 16;
    localparam int unsigned DQM_W     = 2;
    localparam int unsigned CMD_W     = 4;
    localparam int unsigned ERR_W     = 3;
    localparam int unsigned AP_BIT    = 10;

    localparam logic [CMD_W-1:0] CMD_NOP = 4'b0111;
    localparam logic [CMD_W-1:0] CMD_ACT = 4'b0011;
    localparam logic [CMD_W-1:0] CMD_RD  = 4'b0101;
    localparam logic [CMD_W-1:0] CMD_WR  = 4'b0100;
    localparam logic [CMD_W-1:0] CMD_PRE = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_REF = 4'b0001;
    localparam logic [CMD_W-1:0] CMD_LMR = 4'b0000;
    localparam logic [CMD_W-1:0] CMD_BST = 4'b0110;

    localparam logic [ERR_W-1:0] ERR_NONE       = 3'd0;
    localparam logic [ERR_W-1:0] ERR_IDLE_BANK  = 3'd1;
    localparam logic [ERR_W-1:0] ERR_ACT_ACTIVE = 3'd2;
    localparam logic [ERR_W-1:0] ERR_TRCD       = 3'd3;
    localparam logic [ERR_W-1:0] ERR_NOT_IDLE   = 3'd4;
    localparam logic [ERR_W-1:0] ERR_NO_MODE    = 3'd5;
    localparam logic [ERR_W-1:0] ERR_BAD_MODE   = 3'd6;

    localparam int unsigned MODE_CL_LSB = 4;
    localparam int unsigned MODE_CL_W   = 3;
    localparam int unsigned MODE_BL_LSB = 0;
    localparam int unsigned MODE_BL_W   = 3;
    localparam logic [MODE_CL_W-1:0] MODE_CL2 = 3'd2;
    localparam logic [MODE_CL_W-1:0] MODE_CL3 = 3'd3;
    localparam logic [MODE_BL_W-1:0] MODE_BL1 = 3'd0;

    typedef struct packed {
        logic             valid;
        logic             cl2;
        logic [DQM_W-1:0] oe;
    } rd_tag_t;

endpackage

// File: rtl/sdram_emu_ram.sv
// sdram_emu_ram: single-port synchronous RAM backing the SDRAM emulator.
//   clk_64    clock
//   i_we      write strobe, i_be selects the bytes written
//   i_re      read strobe, o_rdata updates on the same edge (1-cycle read)
//   i_addr    word address
//   i_wdata   write data
//   o_rdata   registered read data, held between reads
// Contents are not reset so data survives a controller re-initialisation.
module sdram_emu_ram
    import sdram_pkg::*;
#(
    parameter int unsigned AW = 15
) (
    input  logic              clk_64,
    input  logic              i_we,
    input  logic [DQM_W-1:0]  i_be,
    input  logic              i_re,
    input  logic [AW-1:0]     i_addr,
    input  logic [DQ_W-1:0]   i_wdata,
    output logic [DQ_W-1:0]   o_rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DQ_W-1:0] r_mem [DEPTH];
    logic [DQ_W-1:0] r_q;

    // Byte-lane writes and registered read share one port.
    always_ff @(posedge clk_64) begin
        if (i_we) begin
            if (i_be[0]) r_mem[i_addr][7:0]  <= i_wdata[7:0];
            if (i_be[1]) r_mem[i_addr][15:8] <= i_wdata[15:8];
        end
        if (i_re) r_q <= r_mem[i_addr];
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/sdram_emu.sv
// sdram_emu: responder for an MT48LC16M16-style SDRAM command bus.
//   clk_64     clock, commands sampled on the rising edge
//   reset      synchronous, active-high
//   sd_cs/ras/cas/we  active-low command strobes
//   sd_ba      bank address
//   sd_addr    row / column / mode address, A10 = auto or all-bank precharge
//   sd_dqm     byte masks for writes and read output enables
//   sd_dq_i    write data
//   sd_dq_o    read data, valid for one cycle per read
//   sd_dq_oe   per-byte output enable accompanying sd_dq_o
//   cmd_err    sticky protocol-violation flag
//   err_code   code of the first violation since reset
module sdram_emu
    import sdram_pkg::*;
#(
    parameter int unsigned ROW_BITS = 4,
    parameter int unsigned COL_BITS = 9,
    parameter int unsigned T_RCD    = 2
) (
    input  logic              clk_64,
    input  logic              reset,
    input  logic              sd_cs,
    input  logic              sd_ras,
    input  logic              sd_cas,
    input  logic              sd_we,
    input  logic [BA_W-1:0]   sd_ba,
    input  logic [ADDR_W-1:0] sd_addr,
    input  logic [DQM_W-1:0]  sd_dqm,
    input  logic [DQ_W-1:0]   sd_dq_i,
    output logic [DQ_W-1:0]   sd_dq_o,
    output logic [DQM_W-1:0]  sd_dq_oe,
    output logic              cmd_err,
    output logic [ERR_W-1:0]  err_code
);

    localparam int unsigned AW    = BA_W + ROW_BITS + COL_BITS;
    // Counter holds the remaining ACT->RD/WR wait; zero means the bank is usable.
    localparam int unsigned RCD_W = (T_RCD > 2) ? $clog2(T_RCD) : 1;
    localparam logic [RCD_W-1:0] RCD_LOAD = (T_RCD > 0) ? RCD_W'(T_RCD - 1) : '0;

    localparam logic [0:0] BANK_IDLE   = 1'b0;
    localparam logic [0:0] BANK_ACTIVE = 1'b1;

    logic [NUM_BANKS-1:0][0:0]          r_bank_st, w_bank_st_nxt;
    logic [NUM_BANKS-1:0][ROW_BITS-1:0] r_row,     w_row_nxt;
    logic [NUM_BANKS-1:0][RCD_W-1:0]    r_rcd,     w_rcd_nxt;
    logic                               r_mode_valid, w_mode_valid_nxt;
    logic                               r_cl2,        w_cl2_nxt;
    logic                               r_cmd_err,    w_cmd_err_nxt;
    logic [ERR_W-1:0]                   r_err_code,   w_err_code_nxt;
    rd_tag_t                            r_p0, w_p0_nxt;
    rd_tag_t                            r_p1, w_p1_nxt;
    logic [DQ_W-1:0]                    r_p1_data;
    logic [DQ_W-1:0]                    r_dq_o,  w_dq_o_nxt;
    logic [DQM_W-1:0]                   r_dq_oe, w_dq_oe_nxt;

    logic [CMD_W-1:0]     w_cmd;
    logic [ERR_W-1:0]     w_err;
    logic                 w_any_active;
    logic                 w_ram_we;
    logic                 w_ram_re;
    logic [AW-1:0]        w_ram_addr;
    logic [DQ_W-1:0]      w_ram_q;
    logic [MODE_CL_W-1:0] w_mode_cl;
    logic [MODE_BL_W-1:0] w_mode_bl;
    logic                 w_unused;

    // With cs high the top bit is 1, which matches no command code: INHIBIT.
    assign w_cmd      = {sd_cs, sd_ras, sd_cas, sd_we};
    assign w_ram_addr = {sd_ba, r_row[sd_ba], sd_addr[COL_BITS-1:0]};
    assign w_mode_cl  = sd_addr[MODE_CL_LSB +: MODE_CL_W];
    assign w_mode_bl  = sd_addr[MODE_BL_LSB +: MODE_BL_W];
    // Upper row/column bits are deliberately aliased away.
    assign w_unused   = ^sd_addr;

    // Command decode, bank state machines, error capture and read-pipe steering.
    always_comb begin
        w_bank_st_nxt    = r_bank_st;
        w_row_nxt        = r_row;
        w_mode_valid_nxt = r_mode_valid;
        w_cl2_nxt        = r_cl2;
        w_cmd_err_nxt    = r_cmd_err;
        w_err_code_nxt   = r_err_code;
        w_err            = ERR_NONE;
        w_ram_we         = 1'b0;
        w_ram_re         = 1'b0;
        w_p0_nxt         = '0;
        w_p1_nxt         = '0;
        w_dq_o_nxt       = '0;
        w_dq_oe_nxt      = '0;
        w_any_active     = 1'b0;

        for (int b = 0; b < NUM_BANKS; b++) begin
            w_rcd_nxt[b] = (r_rcd[b] != '0) ? RCD_W'(r_rcd[b] - 1'b1) : '0;
            if (r_bank_st[b] == BANK_ACTIVE) w_any_active = 1'b1;
        end

        case (w_cmd)
            CMD_ACT: begin
                if (!r_mode_valid) begin
                    w_err = ERR_NO_MODE;
                end else if (r_bank_st[sd_ba] == BANK_ACTIVE) begin
                    w_err = ERR_ACT_ACTIVE;
                end else begin
                    w_bank_st_nxt[sd_ba] = BANK_ACTIVE;
                    w_row_nxt[sd_ba]     = sd_addr[ROW_BITS-1:0];
                    w_rcd_nxt[sd_ba]     = RCD_LOAD;
                end
            end
            CMD_RD, CMD_WR: begin
                if (!r_mode_valid) begin
                    w_err = ERR_NO_MODE;
                end else if (r_bank_st[sd_ba] == BANK_IDLE) begin
                    w_err = ERR_IDLE_BANK;
                end else begin
                    // Early access is flagged but still performed.
                    if (r_rcd[sd_ba] != '0) w_err = ERR_TRCD;
                    if (w_cmd == CMD_WR) begin
                        w_ram_we = 1'b1;
                    end else begin
                        w_ram_re       = 1'b1;
                        w_p0_nxt.valid = 1'b1;
                        w_p0_nxt.cl2   = r_cl2;
                        w_p0_nxt.oe    = ~sd_dqm;
                    end
                    // Auto-precharge closes the bank so an ACT next edge is legal.
                    if (sd_addr[AP_BIT]) w_bank_st_nxt[sd_ba] = BANK_IDLE;
                end
            end
            CMD_PRE: begin
                if (sd_addr[AP_BIT]) begin
                    for (int b = 0; b < NUM_BANKS; b++) w_bank_st_nxt[b] = BANK_IDLE;
                end else begin
                    w_bank_st_nxt[sd_ba] = BANK_IDLE;
                end
            end
            CMD_REF: begin
                if (w_any_active) w_err = ERR_NOT_IDLE;
            end
            CMD_LMR: begin
                if (w_any_active) begin
                    w_err = ERR_NOT_IDLE;
                end else begin
                    // Unsupported CL falls back to 3; BL is always treated as 1.
                    w_mode_valid_nxt = 1'b1;
                    w_cl2_nxt        = (w_mode_cl == MODE_CL2);
                    if (((w_mode_cl != MODE_CL2) && (w_mode_cl != MODE_CL3)) ||
                        (w_mode_bl != MODE_BL1)) begin
                        w_err = ERR_BAD_MODE;
                    end
                end
            end
            default: ;
        endcase

        if (!r_cmd_err && (w_err != ERR_NONE)) begin
            w_cmd_err_nxt  = 1'b1;
            w_err_code_nxt = w_err;
        end

        // CL is carried per read, so a mode change never disturbs reads in flight.
        if (r_p0.valid && !r_p0.cl2) w_p1_nxt = r_p0;

        if (r_p0.valid && r_p0.cl2) begin
            w_dq_o_nxt  = w_ram_q;
            w_dq_oe_nxt = r_p0.oe;
        end else if (r_p1.valid) begin
            w_dq_o_nxt  = r_p1_data;
            w_dq_oe_nxt = r_p1.oe;
        end
    end

    // State registers; reset leaves RAM contents untouched.
    always_ff @(posedge clk_64) begin
        if (reset) begin
            for (int b = 0; b < NUM_BANKS; b++) r_bank_st[b] <= BANK_IDLE;
            r_row        <= '0;
            r_rcd        <= '0;
            r_mode_valid <= 1'b0;
            r_cl2        <= 1'b0;
            r_cmd_err    <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_p0         <= '0;
            r_p1         <= '0;
            r_p1_data    <= '0;
            r_dq_o       <= '0;
            r_dq_oe      <= '0;
        end else begin
            r_bank_st    <= w_bank_st_nxt;
            r_row        <= w_row_nxt;
            r_rcd        <= w_rcd_nxt;
            r_mode_valid <= w_mode_valid_nxt;
            r_cl2        <= w_cl2_nxt;
            r_cmd_err    <= w_cmd_err_nxt;
            r_err_code   <= w_err_code_nxt;
            r_p0         <= w_p0_nxt;
            r_p1         <= w_p1_nxt;
            r_p1_data    <= w_ram_q;
            r_dq_o       <= w_dq_o_nxt;
            r_dq_oe      <= w_dq_oe_nxt;
        end
    end

    sdram_emu_ram #(
        .AW (AW)
    ) u_ram (
        .clk_64  (clk_64),
        .i_we    (w_ram_we & ~reset),
        .i_be    (~sd_dqm),
        .i_re    (w_ram_re & ~reset),
        .i_addr  (w_ram_addr),
        .i_wdata (sd_dq_i),
        .o_rdata (w_ram_q)
    );

    assign sd_dq_o  = r_dq_o;
    assign sd_dq_oe = r_dq_oe;
    assign cmd_err  = r_cmd_err;
    assign err_code = r_err_code;

endmodule

// File: tb/tb_sdram_emu.sv
// tb_sdram_emu: directed vector table, hand sequences and random traffic for
// sdram_emu, checked every cycle against a command-level SDRAM model.
module tb_sdram_emu;
    import sdram_pkg::*;

    localparam int unsigned ROW_BITS = 4;
    localparam int unsigned COL_BITS = 9;
    localparam int          T_RCD    = 2;

    logic        clk_64 = 1'b0;
    logic        reset  = 1'b1;
    logic        sd_cs  = 1'b0, sd_ras = 1'b1, sd_cas = 1'b1, sd_we = 1'b1;
    logic [1:0]  sd_ba   = '0;
    logic [12:0] sd_addr = '0;
    logic [1:0]  sd_dqm  = '0;
    logic [15:0] sd_dq_i = '0;
    logic [15:0] sd_dq_o;
    logic [1:0]  sd_dq_oe;
    logic        cmd_err;
    logic [2:0]  err_code;

    sdram_emu #(.ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .T_RCD(T_RCD)) dut (
        .clk_64(clk_64), .reset(reset), .sd_cs(sd_cs), .sd_ras(sd_ras),
        .sd_cas(sd_cas), .sd_we(sd_we), .sd_ba(sd_ba), .sd_addr(sd_addr),
        .sd_dqm(sd_dqm), .sd_dq_i(sd_dq_i), .sd_dq_o(sd_dq_o),
        .sd_dq_oe(sd_dq_oe), .cmd_err(cmd_err), .err_code(err_code)
    );

    always #5 clk_64 = ~clk_64;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp, input logic [15:0] km);
        n_checks++;
        if ((act & km) !== (exp & km)) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h (mask 0x%04h)", name, act, exp, km);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [1:0]  oe;
        logic [15:0] d;
        logic [15:0] km;
    } sched_t;

    logic        m_act [4];
    int          m_row [4];
    int          m_act_edge [4];
    logic        m_mode_valid = 1'b0;
    int          m_cl = 3;
    logic        m_err = 1'b0;
    logic [2:0]  m_code = 3'd0;
    logic [15:0] m_mem [int];
    logic [1:0]  m_known [int];
    sched_t      m_sched [int];
    int          edge_n = 0;
    logic [1:0]  e_oe;
    logic [15:0] e_dq;
    logic [15:0] e_km;

    task automatic model_edge(input logic rst, input logic [3:0] cmd, input logic [1:0] ba,
                              input logic [12:0] addr, input logic [1:0] dqm, input logic [15:0] dq);
        logic [2:0]  err;
        logic        any;
        int          b;
        int          idx;
        int          cl;
        int          bl;
        logic [1:0]  k;
        logic [15:0] w;
        sched_t      s;
        edge_n++;
        err = 3'd0;
        b   = int'(ba);
        any = m_act[0] | m_act[1] | m_act[2] | m_act[3];
        idx = b * (1 << (ROW_BITS + COL_BITS)) + (m_row[b] % (1 << ROW_BITS)) * (1 << COL_BITS)
              + (int'(addr) % (1 << COL_BITS));
        if (rst) begin
            for (int i = 0; i < 4; i++) m_act[i] = 1'b0;
            m_mode_valid = 1'b0;
            m_cl         = 3;
            m_err        = 1'b0;
            m_code       = 3'd0;
            m_sched.delete();
        end else begin
            case (cmd)
                CMD_ACT: begin
                    if (!m_mode_valid) err = 3'd5;
                    else if (m_act[b]) err = 3'd2;
                    else begin
                        m_act[b] = 1'b1; m_row[b] = int'(addr); m_act_edge[b] = edge_n;
                    end
                end
                CMD_RD, CMD_WR: begin
                    if (!m_mode_valid) err = 3'd5;
                    else if (!m_act[b]) err = 3'd1;
                    else begin
                        if (edge_n - m_act_edge[b] < T_RCD) err = 3'd3;
                        w = m_mem.exists(idx) ? m_mem[idx] : 16'h0;
                        k = m_known.exists(idx) ? m_known[idx] : 2'b00;
                        if (cmd == CMD_WR) begin
                            if (!dqm[0]) begin w[7:0]  = dq[7:0];  k[0] = 1'b1; end
                            if (!dqm[1]) begin w[15:8] = dq[15:8]; k[1] = 1'b1; end
                            m_mem[idx]   = w;
                            m_known[idx] = k;
                        end else begin
                            s.oe = ~dqm;
                            s.d  = w;
                            s.km = {{8{k[1]}}, {8{k[0]}}};
                            m_sched[edge_n + m_cl - 1] = s;
                        end
                        if (addr[10]) m_act[b] = 1'b0;
                    end
                end
                CMD_PRE: begin
                    if (addr[10]) for (int i = 0; i < 4; i++) m_act[i] = 1'b0;
                    else m_act[b] = 1'b0;
                end
                CMD_REF: if (any) err = 3'd4;
                CMD_LMR: begin
                    if (any) err = 3'd4;
                    else begin
                        cl = int'(addr[6:4]);
                        bl = int'(addr[2:0]);
                        m_mode_valid = 1'b1;
                        m_cl = (cl == 2) ? 2 : 3;
                        if ((cl != 2 && cl != 3) || bl != 0) err = 3'd6;
                    end
                end
                default: ;
            endcase
            if (err != 3'd0 && !m_err) begin
                m_err  = 1'b1;
                m_code = err;
            end
        end
        if (m_sched.exists(edge_n)) begin
            e_oe = m_sched[edge_n].oe;
            e_dq = m_sched[edge_n].d;
            e_km = m_sched[edge_n].km;
            m_sched.delete(edge_n);
        end else begin
            e_oe = 2'b00; e_dq = 16'h0; e_km = 16'hFFFF;
        end
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge.
    task automatic tick(input logic rst, input logic [3:0] cmd, input logic [1:0] ba,
                        input logic [12:0] addr, input logic [1:0] dqm, input logic [15:0] dq);
        reset = rst;
        {sd_cs, sd_ras, sd_cas, sd_we} = cmd;
        sd_ba = ba; sd_addr = addr; sd_dqm = dqm; sd_dq_i = dq;
        @(posedge clk_64);
        model_edge(rst, cmd, ba, addr, dqm, dq);
        @(negedge clk_64);
        check($sformatf("oe@%0d", edge_n),   16'(sd_dq_oe), 16'(e_oe),   16'hFFFF);
        check($sformatf("dq@%0d", edge_n),   sd_dq_o,       e_dq,        e_km);
        check($sformatf("err@%0d", edge_n),  16'(cmd_err),  16'(m_err),  16'hFFFF);
        check($sformatf("code@%0d", edge_n), 16'(err_code), 16'(m_code), 16'hFFFF);
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, CMD_NOP, 2'd0, 13'h0, 2'b00, 16'h0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
        logic [1:0]  dqm;
        logic [15:0] dq;
        logic [1:0]  e_oe;
        logic [15:0] e_dq;
        logic        e_err;
        logic [2:0]  e_code;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a,
                                input logic [1:0] m, input logic [15:0] d, input logic [1:0] eoe,
                                input logic [15:0] edq, input logic eerr, input logic [2:0] ecode);
        vec_t v;
        v.cmd = c; v.ba = b; v.addr = a; v.dqm = m; v.dq = d;
        v.e_oe = eoe; v.e_dq = edq; v.e_err = eerr; v.e_code = ecode;
        return v;
    endfunction

    vec_t vecs [30];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [12:0] lmr_opts [6];
        logic [3:0]  c;
        logic [12:0] a;
        int          r;
        lmr_opts = '{13'h230, 13'h220, 13'h020, 13'h030, 13'h240, 13'h221};

        vecs[0]  = mk(CMD_PRE, 2'd0, 13'h400, 2'b00, 16'h0,    2'b00, 16'h0,    1'b0, 3'd0);
        vecs[1]  = mk(CMD_LMR, 2'd0, 13'h230, 2'b00, 16'h0,    2'b00, 16'h0,    1'b0, 3'd0);
        vecs[2]  = mk(CMD_ACT, 2'd1, 13'h005, 2'b00, 16'h0,    2'b00, 16'h0,    1'b0, 3'd0);
        vecs[3]  = mk(CMD_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    2'b00, 16'h0,    1'b0, 3'd0);
        vecs[4]  = mk(CMD_WR,  2'd1, 13'h5A3, 2'b00, 16'hBEEF, 2'b00, 16'h0,    1'b0, 3'd0);
        vecs[5]  = mk(CMD_ACT, 2'd1, 13'h005, 2'b00, 16'h0,    2'b00, 16'h0,    1'b0, 3'd0);
        vecs[6]  = mk(CMD_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    2'b00, 16'h0,    1'b0, 3'd0);
        vecs[7]  = mk(CMD_RD,  2'd1, 13'h1A3, 2'b00, 16'h0,    2'b00, 16'h0,    1'b0, 3'd0);
        vecs[8]  = mk(CMD_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    2'b00, 16'h0,    1'b0, 3'd0);
        vecs[9]  = mk(CMD_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    2'b11, 16'hBEEF, 1'b0, 3'd0);
        vecs[10] = mk(CMD_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    2'b00, 16'h0,    1'b0, 3'd0);
        vecs[11] = mk(CMD_WR,  2'd1, 13'h1A3, 2'b10, 16'h1234, 2'b00, 16'h0,    1'b0, 3'd0);
        vecs[12] = mk(CMD_RD,  2'd1, 13'h1A3, 2'b00, 16'h0,    2'b00, 16'h0,    1'b0, 3'd0);
        vecs[13] = mk(CMD_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    2'b00, 16'h0,    1'b0, 3'd0);
        vecs[14] = mk(CMD_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    2'b11, 16'hBE34, 1'b0, 3'd0);
        vecs[15] = mk(CMD_RD,  2'd1, 13'h1A3, 2'b01, 16'h0,    2'b00, 16'h0,    1'b0, 3'd0);
        vecs[16] = mk(CMD_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    2'b00, 16'h0,    1'b0, 3'd0);
        vecs[17] = mk(CMD_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    2'b10, 16'hBE34, 1'b0, 3'd0);
        vecs[18] = mk(CMD_PRE, 2'd1, 13'h000, 2'b00, 16'h0,    2'b00, 16'h0,    1'b0, 3'd0);
        vecs[19] = mk(CMD_LMR, 2'd0, 13'h220, 2'b00, 16'h0,    2'b00, 16'h0,    1'b0, 3'd0);
        vecs[20] = mk(CMD_ACT, 2'd1, 13'h005, 2'b00, 16'h0,    2'b00, 16'h0,    1'b0, 3'd0);
        vecs[21] = mk(CMD_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    2'b00, 16'h0,    1'b0, 3'd0);
        vecs[22] = mk(CMD_RD,  2'd1, 13'h1A3, 2'b00, 16'h0,    2'b00, 16'h0,    1'b0, 3'd0);
        vecs[23] = mk(CMD_RD,  2'd1, 13'h1A3, 2'b00, 16'h0,    2'b11, 16'hBE34, 1'b0, 3'd0);
        vecs[24] = mk(CMD_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    2'b11, 16'hBE34, 1'b0, 3'd0);
        vecs[25] = mk(CMD_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    2'b00, 16'h0,    1'b0, 3'd0);
        vecs[26] = mk(CMD_RD,  2'd2, 13'h000, 2'b00, 16'h0,    2'b00, 16'h0,    1'b1, 3'd1);
        vecs[27] = mk(CMD_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    2'b00, 16'h0,    1'b1, 3'd1);
        vecs[28] = mk(CMD_ACT, 2'd1, 13'h007, 2'b00, 16'h0,    2'b00, 16'h0,    1'b1, 3'd1);
        vecs[29] = mk(CMD_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    2'b00, 16'h0,    1'b1, 3'd1);

        for (int i = 0; i < 4; i++) begin
            m_act[i] = 1'b0; m_row[i] = 0; m_act_edge[i] = 0;
        end

        @(negedge clk_64);
        for (int i = 0; i < 3; i++) tick(1'b1, CMD_NOP, 2'd0, 13'h0, 2'b00, 16'h0);
        check("reset_oe",  16'(sd_dq_oe), 16'h0, 16'hFFFF);
        check("reset_err", 16'(cmd_err),  16'h0, 16'hFFFF);

        for (int i = 0; i < 30; i++) begin
            tick(1'b0, vecs[i].cmd, vecs[i].ba, vecs[i].addr, vecs[i].dqm, vecs[i].dq);
            check($sformatf("vec%0d_oe", i),   16'(sd_dq_oe), 16'(vecs[i].e_oe),   16'hFFFF);
            check($sformatf("vec%0d_dq", i),   sd_dq_o,       vecs[i].e_dq,        16'hFFFF);
            check($sformatf("vec%0d_err", i),  16'(cmd_err),  16'(vecs[i].e_err),  16'hFFFF);
            check($sformatf("vec%0d_code", i), 16'(err_code), 16'(vecs[i].e_code), 16'hFFFF);
        end

        // Reset one edge after a read: the read never drives, RAM survives.
        tick(1'b0, CMD_PRE, 2'd0, 13'h400, 2'b00, 16'h0);
        tick(1'b0, CMD_LMR, 2'd0, 13'h230, 2'b00, 16'h0);
        tick(1'b0, CMD_ACT, 2'd1, 13'h005, 2'b00, 16'h0);
        nop(1);
        tick(1'b0, CMD_RD, 2'd1, 13'h1A3, 2'b00, 16'h0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, CMD_NOP, 2'd0, 13'h0, 2'b00, 16'h0);
            check($sformatf("rstrd_oe%0d", i), 16'(sd_dq_oe), 16'h0, 16'hFFFF);
        end
        nop(1);
        check("rstrd_oe3",  16'(sd_dq_oe), 16'h0, 16'hFFFF);
        check("rstrd_err",  16'(cmd_err),  16'h0, 16'hFFFF);
        tick(1'b0, CMD_LMR, 2'd0, 13'h230, 2'b00, 16'h0);
        check("rstrd_idle", 16'(cmd_err),  16'h0, 16'hFFFF);
        tick(1'b0, CMD_ACT, 2'd1, 13'h005, 2'b00, 16'h0);
        nop(1);
        tick(1'b0, CMD_RD, 2'd1, 13'h1A3, 2'b00, 16'h0);
        nop(2);
        check("rstrd_keep_dq", sd_dq_o,         16'hBE34, 16'hFFFF);
        check("rstrd_keep_oe", 16'(sd_dq_oe),   16'h3,    16'hFFFF);

        // Write one edge after ACT: flagged as tRCD violation but still executed.
        tick(1'b1, CMD_NOP, 2'd0, 13'h0, 2'b00, 16'h0);
        tick(1'b0, CMD_LMR, 2'd0, 13'h220, 2'b00, 16'h0);
        tick(1'b0, CMD_ACT, 2'd0, 13'h001, 2'b00, 16'h0);
        tick(1'b0, CMD_WR,  2'd0, 13'h010, 2'b00, 16'h5A5A);
        check("trcd_code", 16'(err_code), 16'h3, 16'hFFFF);
        tick(1'b0, CMD_RD,  2'd0, 13'h010, 2'b00, 16'h0);
        nop(1);
        check("trcd_dq",   sd_dq_o, 16'h5A5A, 16'hFFFF);

        // Random traffic on a small aliased address space.
        for (int it = 0; it < 3000; it++) begin
            r = int'($urandom_range(0, 99));
            a = 13'($urandom);
            if (r < 1) begin
                tick(1'b1, CMD_NOP, 2'd0, 13'h0, 2'b00, 16'h0);
                continue;
            end
            if (r < 22)      begin c = CMD_ACT; a = a & 13'h1FF3; end
            else if (r < 47) begin c = CMD_RD;  a = (a & 13'h1A07) | (($urandom_range(0, 3) == 0) ? 13'h400 : 13'h0); end
            else if (r < 67) begin c = CMD_WR;  a = (a & 13'h1A07) | (($urandom_range(0, 3) == 0) ? 13'h400 : 13'h0); end
            else if (r < 79) c = CMD_PRE;
            else if (r < 82) c = CMD_REF;
            else if (r < 88) begin c = CMD_LMR; a = lmr_opts[$urandom_range(0, 5)]; end
            else if (r < 90) c = CMD_BST;
            else if (r < 93) c = {1'b1, 3'($urandom)};
            else             c = CMD_NOP;
            tick(1'b0, c, 2'($urandom), a, 2'($urandom), 16'($urandom));
        end
        nop(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
